// File: rtl/alu_mem.sv
// alu_mem: combinational ALU alongside a byte-wide single-port memory
// with a registered, write-first read port.
// Optional feature macro: ALU_MEM_OVERFLOW_EN adds a combinational signed
// overflow flag for ADD and SUB.
module alu_mem #(
   parameter int ALU_W  = 32,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ALU_W-1:0]  a,
   input  logic [ALU_W-1:0]  b,
   input  logic [2:0]        alu_control,
   output logic [ALU_W-1:0]  result,
   output logic              zero,
`ifdef ALU_MEM_OVERFLOW_EN
   output logic              overflow,
`endif
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] write_data,
   input  logic              write_enable,
   output logic [DATA_W-1:0] read_data
);

   localparam int DEPTH = 1 << ADDR_W;

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_XOR  = 3'b011;
   localparam logic [2:0] OP_NOR  = 3'b100;
   localparam logic [2:0] OP_SLTU = 3'b101;
   localparam logic [2:0] OP_SUB  = 3'b110;
   localparam logic [2:0] OP_SLT  = 3'b111;

   // ---------------- ALU ----------------
   logic [ALU_W-1:0] w_sum;
   logic [ALU_W-1:0] w_diff;
   logic             w_lt_s;
   logic             w_lt_u;
   logic [ALU_W-1:0] w_result;

   // Adder/subtractor wrap modulo 2^ALU_W; carry-out is simply dropped.
   assign w_sum  = a + b;
   assign w_diff = a - b;
   assign w_lt_s = $signed(a) < $signed(b);
   assign w_lt_u = a < b;

   // Operation decode; set-less-than results are zero-extended to full width.
   always_comb begin
      w_result = '0;
      case (alu_control)
         OP_AND:  w_result = a & b;
         OP_OR:   w_result = a | b;
         OP_ADD:  w_result = w_sum;
         OP_XOR:  w_result = a ^ b;
         OP_NOR:  w_result = ~(a | b);
         OP_SLTU: w_result = {{(ALU_W-1){1'b0}}, w_lt_u};
         OP_SUB:  w_result = w_diff;
         OP_SLT:  w_result = {{(ALU_W-1){1'b0}}, w_lt_s};
         default: w_result = '0;
      endcase
   end

   assign result = w_result;
   assign zero   = (w_result == '0);

`ifdef ALU_MEM_OVERFLOW_EN
   logic w_ovf_add;
   logic w_ovf_sub;

   // ADD overflows when like-signed operands give an opposite-signed sum;
   // SUB overflows when unlike-signed operands give a result whose sign differs from a.
   assign w_ovf_add = (a[ALU_W-1] == b[ALU_W-1]) && (w_sum[ALU_W-1]  != a[ALU_W-1]);
   assign w_ovf_sub = (a[ALU_W-1] != b[ALU_W-1]) && (w_diff[ALU_W-1] != a[ALU_W-1]);

   // Flag is only meaningful for the arithmetic ops; forced low otherwise.
   always_comb begin
      overflow = 1'b0;
      if (alu_control == OP_ADD)      overflow = w_ovf_add;
      else if (alu_control == OP_SUB) overflow = w_ovf_sub;
   end
`endif

   // ---------------- Memory ----------------
   // Array is intentionally not reset so contents survive a reset pulse.
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_read_data;

   // Array write; rst_n gates the strobe so writes during reset are dropped.
   always_ff @(posedge clk) begin
      if (rst_n && write_enable)
         r_mem[address] <= write_data;
   end

   // Registered read, write-first: a same-edge write is forwarded to the output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_read_data <= '0;
      else if (write_enable)
         r_read_data <= write_data;
      else
         r_read_data <= r_mem[address];
   end

   assign read_data = r_read_data;

endmodule

// File: tb/tb_alu_mem.sv
// Self-checking bench for alu_mem: table-driven ALU vectors plus a
// scoreboarded memory sequence including reset corner cases.
module tb_alu_mem;

   logic        clk;
   logic        rst_n;
   logic [31:0] a, b;
   logic [2:0]  alu_control;
   logic [31:0] result;
   logic        zero;
`ifdef ALU_MEM_OVERFLOW_EN
   logic        overflow;
`endif
   logic [15:0] address;
   logic [7:0]  write_data;
   logic        write_enable;
   logic [7:0]  read_data;

   int total = 0;
   int bad   = 0;

   alu_mem dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .alu_control(alu_control),
      .result(result), .zero(zero),
`ifdef ALU_MEM_OVERFLOW_EN
      .overflow(overflow),
`endif
      .address(address), .write_data(write_data),
      .write_enable(write_enable), .read_data(read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  op;
      logic [31:0] res;
      logic        z;
      logic        ov;
   } vec_t;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
   } sb_t;

   vec_t vt[$];
   sb_t  sbq[$];
   logic [7:0] model [logic [15:0]];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, got, exp);
      end
   endtask

   // Drive one memory cycle, predict the read, then compare after the edge.
   task automatic mem_op(input logic [15:0] ad, input logic we, input logic [7:0] wd);
      sb_t e;
      address      = ad;
      write_enable = we;
      write_data   = wd;
      e.addr = ad;
      e.data = we ? wd : model[ad];
      sbq.push_back(e);
      if (we) model[ad] = wd;
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
         total++; bad++;
         $display("FAIL scoreboard_empty: got 0 want 1");
      end else begin
         e = sbq.pop_front();
         chk($sformatf("mem_rd@%h", e.addr), {24'h0, read_data}, {24'h0, e.data});
      end
   endtask

   initial begin
      vt.push_back('{32'h00008000, 32'h00008000, 3'b010, 32'h00010000, 1'b0, 1'b0});
      vt.push_back('{32'h12345678, 32'h12345678, 3'b110, 32'h00000000, 1'b1, 1'b0});
      vt.push_back('{32'hFFFFFFFF, 32'h00000001, 3'b111, 32'h00000001, 1'b0, 1'b0});
      vt.push_back('{32'hFFFFFFFF, 32'h00000001, 3'b101, 32'h00000000, 1'b1, 1'b0});
      vt.push_back('{32'hF0F0F0F0, 32'h0FF00FF0, 3'b000, 32'h00F000F0, 1'b0, 1'b0});
      vt.push_back('{32'hF0F0F0F0, 32'h0F0F0F0F, 3'b001, 32'hFFFFFFFF, 1'b0, 1'b0});
      vt.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 3'b011, 32'h00000000, 1'b1, 1'b0});
      vt.push_back('{32'h12345678, 32'h0000FFFF, 3'b011, 32'h1234A987, 1'b0, 1'b0});
      vt.push_back('{32'h00000000, 32'h00000000, 3'b100, 32'hFFFFFFFF, 1'b0, 1'b0});
      vt.push_back('{32'hFFFFFFFF, 32'h00000001, 3'b010, 32'h00000000, 1'b1, 1'b0});
      vt.push_back('{32'h00000000, 32'h00000001, 3'b110, 32'hFFFFFFFF, 1'b0, 1'b0});
      vt.push_back('{32'h00000001, 32'hFFFFFFFF, 3'b101, 32'h00000001, 1'b0, 1'b0});
      vt.push_back('{32'h80000000, 32'h7FFFFFFF, 3'b111, 32'h00000001, 1'b0, 1'b0});
      vt.push_back('{32'h7FFFFFFF, 32'h80000000, 3'b111, 32'h00000000, 1'b1, 1'b0});
      vt.push_back('{32'h7FFFFFFF, 32'h00000001, 3'b010, 32'h80000000, 1'b0, 1'b1});
      vt.push_back('{32'h80000000, 32'h00000001, 3'b110, 32'h7FFFFFFF, 1'b0, 1'b1});
      vt.push_back('{32'h80000000, 32'h00000001, 3'b000, 32'h00000000, 1'b1, 1'b0});

      a = '0; b = '0; alu_control = '0;
      address = '0; write_data = '0; write_enable = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk("reset_read_data", {24'h0, read_data}, 32'h0);

      // ALU vectors: purely combinational, checked after a short settle.
      foreach (vt[i]) begin
         a = vt[i].a; b = vt[i].b; alu_control = vt[i].op;
         #1;
         chk($sformatf("alu_res[%0d]", i), result, vt[i].res);
         chk($sformatf("alu_zero[%0d]", i), {31'h0, zero}, {31'h0, vt[i].z});
`ifdef ALU_MEM_OVERFLOW_EN
         chk($sformatf("alu_ovf[%0d]", i), {31'h0, overflow}, {31'h0, vt[i].ov});
`endif
      end

      // Release reset just after an edge; the next edge is the first capture.
      @(posedge clk); #1;
      chk("reset_hold", {24'h0, read_data}, 32'h0);
      rst_n = 1'b1;

      mem_op(16'h0000, 1'b1, 8'hFF);
      mem_op(16'hFFFF, 1'b1, 8'hA5);
      mem_op(16'h0000, 1'b1, 8'h5A);
      mem_op(16'hFFFF, 1'b0, 8'h00);
      mem_op(16'h0000, 1'b0, 8'h11);

      for (int i = 0; i < 8; i++)
         mem_op(16'h0100 + 16'(i * 37), 1'b1, 8'($urandom_range(0, 255)));
      for (int i = 7; i >= 0; i--)
         mem_op(16'h0100 + 16'(i * 37), 1'b0, 8'($urandom_range(0, 255)));

      // Reset mid-cycle: output clears at once, write under reset is dropped.
      mem_op(16'h0010, 1'b1, 8'h3C);
      #3 rst_n = 1'b0;
      #1;
      chk("async_reset_clear", {24'h0, read_data}, 32'h0);
      address = 16'h0010; write_data = 8'h77; write_enable = 1'b1;
      @(posedge clk); #1;
      chk("write_in_reset", {24'h0, read_data}, 32'h0);
      write_enable = 1'b0;
      #3 rst_n = 1'b1;
      @(negedge clk);
      mem_op(16'h0010, 1'b0, 8'h00);
      mem_op(16'hFFFF, 1'b0, 8'h00);

      if (sbq.size() != 0) begin
         total++; bad++;
         $display("FAIL scoreboard_leftover: got %0d want 0", sbq.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_mem.md
ALU_MEM -- requirements
Module: alu_mem

Interface
REQ-001 Parameter ALU_W, default 32, ALU operand/result width.
REQ-002 Parameter ADDR_W, default 16, memory address width; depth = 2^ADDR_W bytes.
REQ-003 Parameter DATA_W, default 8, memory word width.
REQ-004 clk  input  1  single clock; all sequential logic on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 a  input  ALU_W  ALU operand A.
REQ-007 b  input  ALU_W  ALU operand B.
REQ-008 alu_control  input  3  ALU operation select.
REQ-009 result  output  ALU_W  ALU result.
REQ-010 zero  output  1  high when result is all zeros.
REQ-011 address  input  ADDR_W  memory byte address for read and write.
REQ-012 write_data  input  DATA_W  memory write data.
REQ-013 write_enable  input  1  write strobe, sampled on clk rising edge.
REQ-014 read_data  output  DATA_W  registered memory read data.

Function
REQ-015 ALU SHALL be purely combinational, zero latency, independent of clk and rst_n.
REQ-016 alu_control decode SHALL be: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 101 SLTU, 110 SUB (a-b), 111 SLT (signed).
REQ-017 ADD/SUB SHALL wrap modulo 2^ALU_W; carry-out discarded.
REQ-018 SLT/SLTU SHALL drive result = 1 when a<b (signed / unsigned respectively), else 0; upper bits zero.
REQ-019 zero SHALL equal 1 exactly when result == 0, for every operation.
REQ-020 On each clk rising edge with rst_n high and write_enable high, mem[address] SHALL be loaded with write_data.
REQ-021 On each clk rising edge with rst_n high, read_data SHALL be loaded with mem[address] (1-cycle latency), regardless of write_enable.
REQ-022 Simultaneous write and read of the same address SHALL be write-first: read_data takes write_data that edge.
REQ-023 Full address range SHALL be valid; no wrap or aliasing; no out-of-range condition exists.
REQ-024 Unwritten locations SHALL read as undefined (X in simulation); array has no initialisation.

Reset
REQ-025 rst_n low SHALL force read_data to 0 immediately, independent of clk.
REQ-026 While rst_n is low, writes SHALL be suppressed; a write coinciding with reset assertion is discarded.
REQ-027 Memory array contents SHALL NOT be cleared by reset; data written before reset remains readable after release.
REQ-028 First read capture SHALL occur on the first clk rising edge after rst_n deasserts.

Configuration
REQ-029 Macro ALU_MEM_OVERFLOW_EN defined: extra output port overflow (1 bit, combinational), high on signed overflow of ADD or SUB, 0 for all other operations.
REQ-030 ALU_MEM_OVERFLOW_EN undefined: overflow port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-031 a=0x00008000, b=0x00008000, alu_control=010 -> result=0x00010000, zero=0.
REQ-032 a=0x12345678, b=0x12345678, alu_control=110 -> result=0, zero=1; a=0xFFFFFFFF, b=1, alu_control=111 -> result=1; same with 101 -> result=0.
REQ-033 Reset released, address=0x0000, write_data=0xFF, write_enable=1, one clk edge -> read_data=0xFF after that edge (write-first).
REQ-034 Write 0xA5 to 0xFFFF, 0x5A to 0x0000, then read both with write_enable=0 -> 0xA5 then 0x5A, one cycle after each address is applied.
REQ-035 Write 0x3C to 0x0010, assert rst_n low mid-cycle -> read_data=0 immediately; write 0x77 with rst_n low -> ignored; release, read 0x0010 -> 0x3C.
REQ-036 With ALU_MEM_OVERFLOW_EN: a=0x7FFFFFFF, b=1, ADD -> result=0x80000000, overflow=1; a=0x80000000, b=1, SUB -> overflow=1; AND -> overflow=0.
